// File: rtl/img_pkg.sv
// Shared constants and capture state encoding for the image capture path.
package img_pkg;
  localparam int IMG_WIDTH = 410;
  localparam int IMG_DEPTH = 361;
  localparam int IMG_PIX_W = 8;
  localparam int FRAME_PIX = IMG_WIDTH * IMG_DEPTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;
endpackage

// File: rtl/frame_buffer_1r1w.sv
// Single-clock simple dual-port RAM: one write port, one registered read-first read port.
module frame_buffer_1r1w #(
  parameter int WORDS  = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [WORDS];

  // Read and write share one block so a same-address access returns the old word.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/image_capture.sv
// Captures one WIDTH*DEPTH frame after a level change on finish, with checksum and readback.
module image_capture
  import img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int DEPTH  = IMG_DEPTH,
  parameter int PIX_W  = IMG_PIX_W,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              finish,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ADDR_W-1:0] pixel_count,
  output logic [31:0]       checksum
);
  localparam int FRAME_N = WIDTH * DEPTH;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_N - 1);

  cap_state_e state, state_nxt;
  logic finish_q, toggle, wr_en;

  assign toggle = finish != finish_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = ARMED;
      ARMED:   if (toggle) state_nxt = CAPTURE;
      CAPTURE: if (pixel_count == LAST) state_nxt = DONE;
      DONE:    if (arm) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // A write never lands on a reset edge, so an aborted capture leaves the buffer as-is.
  always_comb begin
    busy  = state == CAPTURE;
    done  = state == DONE;
    wr_en = !rst && ((state == ARMED && toggle) || state == CAPTURE);
  end

  always_ff @(posedge clk) begin
    finish_q <= finish;
    if (rst) begin
      pixel_count <= '0;
      checksum    <= '0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (arm) begin
          pixel_count <= '0;
          checksum    <= '0;
          overrun     <= 1'b0;
        end
        ARMED: if (toggle) begin
          pixel_count <= ADDR_W'(1);
          checksum    <= 32'(pixel_in);
        end
        CAPTURE: begin
          pixel_count <= pixel_count + 1'b1;
          checksum    <= checksum + 32'(pixel_in);
          if (toggle) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  frame_buffer_1r1w #(
    .WORDS (FRAME_N),
    .DATA_W(PIX_W),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(pixel_count),
    .wr_data(pixel_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: doc/image_capture.md
Name: image_capture

Overview:
- Receive-side counterpart of the brightness/median pixel processing blocks. Those blocks stream a processed frame out on an 8-bit pixel bus, one pixel per clock, starting when their `finish` line changes level.
- image_capture watches for that change and writes WIDTH*DEPTH consecutive pixels into an internal frame buffer. It also computes a running checksum.
- The captured frame is exposed through a synchronous read port for the display/readback path and for self-checking benches.

Parameters:
- WIDTH, 410, pixels per row
- DEPTH, 361, rows per frame
- PIX_W, 8, pixel width in bits
- ADDR_W, 18, buffer address width; must satisfy 2^ADDR_W >= WIDTH*DEPTH

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- arm  in  1  single-cycle request to prepare for a new capture
- finish  in  1  level from producer; any transition starts the stream
- pixel_in  in  PIX_W  producer pixel bus
- rd_addr  in  ADDR_W  readback address, linear index row*WIDTH+col
- rd_data  out  PIX_W  readback data, 1-cycle latency
- busy  out  1  high in CAPTURE
- done  out  1  high in DONE
- overrun  out  1  sticky error flag
- pixel_count  out  ADDR_W  pixels written in current or last capture
- checksum  out  32  sum of captured pixels, modulo 2^32

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, named rst; clock is clk.
- Reset values: busy=0, done=0, overrun=0, pixel_count=0, checksum=0; state=IDLE. Buffer contents are not reset. rd_data is the registered read of rd_addr (don't-care during the reset cycle).
- Edge detect: finish_q is finish registered once. While rst=1, finish_q <= finish, so no edge is seen at reset release. A toggle is the condition, sampled at a clock edge, that finish != finish_q. Both rising and falling transitions count.
- Stream timing: the pixel_in sampled at the same edge where the toggle is detected is pixel 0. Pixel k is sampled k edges later. There are no gaps and no valid strobe.
- State IDLE: outputs hold their values. arm=1 moves to ARMED; toggles are ignored.
- State ARMED: on entry, clear done, overrun, pixel_count and checksum. A toggle moves to CAPTURE; the toggle cycle writes pixel 0 to address 0, pixel_count becomes 1, and checksum becomes pixel 0.
- State CAPTURE: busy=1. Each edge writes pixel_in to address pixel_count, increments pixel_count, and adds the zero-extended pixel to checksum.
- End of capture: when the write at address WIDTH*DEPTH-1 occurs, go to DONE. pixel_count is then WIDTH*DEPTH.
- Toggle during CAPTURE: sets overrun=1. The capture is not restarted and the stream continues to be written.
- arm during CAPTURE: ignored.
- State DONE: done=1, busy=0. arm=1 moves to ARMED, which clears done and the counters.
- arm and toggle in the same cycle from IDLE/DONE: arm wins. The block enters ARMED and that toggle is not captured; finish_q still updates.
- Reset during CAPTURE: returns to IDLE on the next edge. Partially written buffer data remains; pixel_count is cleared.
- Read port: always active, including during capture. If rd_addr equals the write address in the same cycle, rd_data returns the old contents (read-first).
- Arithmetic: checksum is a 32-bit unsigned sum that wraps. pixel_count never exceeds WIDTH*DEPTH.

Decomposition:
- Shared package (img_pkg):
  - WIDTH/DEPTH/PIX_W defaults
  - frame-size constant FRAME_PIX = WIDTH*DEPTH
  - capture state enum {IDLE, ARMED, CAPTURE, DONE}
- One sub-module, frame_buffer_1r1w: simple dual-port RAM, single clock, read-first, registered read, parameterised by depth and width.
- Edge detect, FSM and counters stay in the top module.

Test Plan (WIDTH=4, DEPTH=3, FRAME_PIX=12 unless noted):
- Basic capture:
  - Stimulus: rst 2 cycles; arm pulse; finish 0->1 with pixel_in=10,11,...,21 on consecutive cycles.
  - Response: busy high for 11 cycles then done=1; pixel_count=12; checksum=186; rd_addr 0..11 returns 10..21 one cycle later.
- Falling-edge start:
  - Stimulus: after the first capture, arm, then finish 1->0 with pixels all 255.
  - Response: done=1; checksum=3060; overrun=0.
- Unarmed and reset-release safety:
  - Stimulus: hold finish=1 through and after reset with no arm; toggle finish.
  - Response: state stays IDLE; done=0; pixel_count=0; the buffer is not written (read address 0 keeps its prior value).
- Overrun:
  - Stimulus: arm; start a capture; toggle finish again at pixel 5.
  - Response: overrun=1 sticky; capture completes with pixel_count=12; the next arm clears overrun.
- Reset mid-capture and re-arm:
  - Stimulus: rst at pixel 6.
  - Response: next cycle busy=0, pixel_count=0, done=0; arm plus a new stream captures correctly.
- Checksum wrap (default 410x361):
  - Stimulus: all pixels 255.
  - Response: checksum = 148010*255 mod 2^32 = 37742550; pixel_count=148010.
